// File: rtl/hls_exec_monitor.sv
// Execution-profiling monitor for an HLS accelerator: tracks the block ap_* handshake,
// one sequential FSM loop and one pipelined loop with saturating counters; finish freezes everything.
module hls_exec_monitor #(
  parameter int unsigned SEQ_W = 6,
  parameter int unsigned UPC_W = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             finish,
  input  logic             mod_start,
  input  logic             mod_ready,
  input  logic             mod_done,
  input  logic             mod_continue,
  input  logic [SEQ_W-1:0] seq_cur_state,
  input  logic [SEQ_W-1:0] seq_pre_state,
  input  logic [SEQ_W-1:0] seq_post_state,
  input  logic [SEQ_W-1:0] seq_iter_start_state,
  input  logic [SEQ_W-1:0] seq_iter_end_state,
  input  logic             seq_post_valid,
  input  logic             seq_iter_end_valid,
  input  logic             seq_one_state_loop,
  input  logic             seq_one_state_block,
  input  logic [UPC_W-1:0] upc_cur_state,
  input  logic [UPC_W-1:0] upc_iter_start_state,
  input  logic [UPC_W-1:0] upc_iter_end_state,
  input  logic [UPC_W-1:0] upc_quit_state,
  input  logic             upc_iter_start_block,
  input  logic             upc_iter_end_block,
  input  logic             upc_quit_block,
  input  logic             upc_iter_start_enable,
  input  logic             upc_iter_end_enable,
  input  logic             upc_quit_enable,
  input  logic             upc_loop_start,
  input  logic             upc_loop_ready,
  input  logic             upc_loop_done,
  input  logic             upc_loop_continue,
  input  logic             upc_quit_at_end,
  output logic             frozen,
  output logic             mod_busy,
  output logic [CNT_W-1:0] mod_start_cnt,
  output logic [CNT_W-1:0] mod_done_cnt,
  output logic [CNT_W-1:0] mod_busy_cycles,
  output logic             seq_active,
  output logic [CNT_W-1:0] seq_entry_cnt,
  output logic [CNT_W-1:0] seq_iter_cnt,
  output logic [CNT_W-1:0] seq_active_cycles,
  output logic             upc_active,
  output logic [CNT_W-1:0] upc_iter_start_cnt,
  output logic [CNT_W-1:0] upc_iter_end_cnt,
  output logic [CNT_W-1:0] upc_inflight,
  output logic [CNT_W-1:0] upc_active_cycles
);

  typedef enum logic {MOD_IDLE, MOD_BUSY} mod_state_t;
  typedef enum logic {SEQ_OUT, SEQ_IN} seq_state_t;
  typedef enum logic {UPC_IDLE, UPC_ACTIVE} upc_state_t;

  mod_state_t       mod_state;
  seq_state_t       seq_state;
  upc_state_t       upc_state;
  logic [SEQ_W-1:0] seq_prev;
  logic             upc_start_prev;

  // pre_state is carried for debug visibility only
  logic unused_pre;
  assign unused_pre = ^seq_pre_state;

  logic seq_enter_start, seq_enter_end, seq_enter_post;
  logic seq_entry, seq_exit, seq_iter_inc;
  logic upc_start_evt, upc_end_evt, upc_quit_evt;
  logic upc_entry, upc_exit;
  logic hold;

  always_comb begin
    hold            = frozen || finish;
    seq_enter_start = (seq_cur_state == seq_iter_start_state) && (seq_prev != seq_iter_start_state);
    seq_enter_end   = (seq_cur_state == seq_iter_end_state) && (seq_prev != seq_iter_end_state);
    seq_enter_post  = (seq_cur_state == seq_post_state) && (seq_prev != seq_post_state);
    seq_entry       = (seq_state == SEQ_OUT) && seq_enter_start;
    seq_exit        = (seq_state == SEQ_IN) && seq_enter_post && seq_post_valid;
    // iterations count while inside the loop and on the entry edge itself
    seq_iter_inc    = ((seq_state == SEQ_IN) || seq_entry) &&
                      (seq_one_state_loop
                         ? ((seq_cur_state == seq_iter_start_state) && !seq_one_state_block)
                         : (seq_enter_end && seq_iter_end_valid));
    upc_start_evt   = (upc_cur_state == upc_iter_start_state) && !upc_iter_start_block && upc_iter_start_enable;
    upc_end_evt     = (upc_cur_state == upc_iter_end_state) && !upc_iter_end_block && upc_iter_end_enable;
    upc_quit_evt    = (upc_cur_state == upc_quit_state) && !upc_quit_block && upc_quit_enable;
    upc_entry       = (upc_state == UPC_IDLE) &&
                      ((upc_loop_start && upc_loop_ready) || (upc_loop_start && !upc_start_prev));
    upc_exit        = (upc_state == UPC_ACTIVE) &&
                      ((upc_loop_done && upc_loop_continue) || (upc_quit_evt && !upc_quit_at_end));
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      frozen             <= 1'b0;
      mod_state          <= MOD_IDLE;
      seq_state          <= SEQ_OUT;
      upc_state          <= UPC_IDLE;
      seq_prev           <= '0;
      upc_start_prev     <= 1'b0;
      mod_start_cnt      <= '0;
      mod_done_cnt       <= '0;
      mod_busy_cycles    <= '0;
      seq_entry_cnt      <= '0;
      seq_iter_cnt       <= '0;
      seq_active_cycles  <= '0;
      upc_iter_start_cnt <= '0;
      upc_iter_end_cnt   <= '0;
      upc_inflight       <= '0;
      upc_active_cycles  <= '0;
    end else begin
      if (finish) frozen <= 1'b1;
      if (!hold) begin
        case (mod_state)
          MOD_IDLE: if (mod_start) mod_state <= MOD_BUSY;
          MOD_BUSY: if (mod_done && mod_continue && !mod_start) mod_state <= MOD_IDLE;
          default:  mod_state <= MOD_IDLE;
        endcase
        mod_start_cnt   <= sat_inc(mod_start_cnt, mod_start && mod_ready);
        mod_done_cnt    <= sat_inc(mod_done_cnt, mod_done && mod_continue);
        mod_busy_cycles <= sat_inc(mod_busy_cycles, mod_state == MOD_BUSY);

        seq_prev <= seq_cur_state;
        if (seq_exit)       seq_state <= SEQ_OUT;
        else if (seq_entry) seq_state <= SEQ_IN;
        seq_entry_cnt     <= sat_inc(seq_entry_cnt, seq_entry);
        seq_iter_cnt      <= sat_inc(seq_iter_cnt, seq_iter_inc);
        seq_active_cycles <= sat_inc(seq_active_cycles, seq_state == SEQ_IN);

        upc_start_prev <= upc_loop_start;
        if (upc_exit)       upc_state <= UPC_IDLE;
        else if (upc_entry) upc_state <= UPC_ACTIVE;
        upc_iter_start_cnt <= sat_inc(upc_iter_start_cnt, upc_start_evt);
        upc_iter_end_cnt   <= sat_inc(upc_iter_end_cnt, upc_end_evt);
        upc_active_cycles  <= sat_inc(upc_active_cycles, upc_state == UPC_ACTIVE);
        if (upc_start_evt && !upc_end_evt && (upc_inflight != '1))
          upc_inflight <= upc_inflight + CNT_W'(1);
        else if (upc_end_evt && !upc_start_evt && (upc_inflight != '0))
          upc_inflight <= upc_inflight - CNT_W'(1);
      end
    end
  end

  assign mod_busy   = (mod_state == MOD_BUSY);
  assign seq_active = (seq_state == SEQ_IN);
  assign upc_active = (upc_state == UPC_ACTIVE);

endmodule

// File: tb/tb_hls_exec_monitor.sv
// Directed-vector bench for hls_exec_monitor: a 32-bit counter instance for the main
// scenarios and a 4-bit counter instance sharing the same inputs for saturation.
module tb_hls_exec_monitor;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic finish = 1'b0;
  logic mod_start = 1'b0, mod_ready = 1'b0, mod_done = 1'b0, mod_continue = 1'b0;
  logic [5:0] seq_cur_state = 6'd1, seq_pre_state = 6'd1, seq_post_state = 6'd6;
  logic [5:0] seq_iter_start_state = 6'd2, seq_iter_end_state = 6'd5;
  logic seq_post_valid = 1'b0, seq_iter_end_valid = 1'b0;
  logic seq_one_state_loop = 1'b0, seq_one_state_block = 1'b0;
  logic [0:0] upc_cur_state = 1'b0, upc_iter_start_state = 1'b0;
  logic [0:0] upc_iter_end_state = 1'b0, upc_quit_state = 1'b1;
  logic upc_iter_start_block = 1'b0, upc_iter_end_block = 1'b0, upc_quit_block = 1'b0;
  logic upc_iter_start_enable = 1'b0, upc_iter_end_enable = 1'b0, upc_quit_enable = 1'b0;
  logic upc_loop_start = 1'b0, upc_loop_ready = 1'b0, upc_loop_done = 1'b0;
  logic upc_loop_continue = 1'b0, upc_quit_at_end = 1'b0;

  logic frozen, mod_busy, seq_active, upc_active;
  logic [31:0] mod_start_cnt, mod_done_cnt, mod_busy_cycles;
  logic [31:0] seq_entry_cnt, seq_iter_cnt, seq_active_cycles;
  logic [31:0] upc_iter_start_cnt, upc_iter_end_cnt, upc_inflight, upc_active_cycles;

  logic s_frozen, s_mod_busy, s_seq_active, s_upc_active;
  logic [3:0] s_mod_start_cnt, s_mod_done_cnt, s_mod_busy_cycles;
  logic [3:0] s_seq_entry_cnt, s_seq_iter_cnt, s_seq_active_cycles;
  logic [3:0] s_upc_iter_start_cnt, s_upc_iter_end_cnt, s_upc_inflight, s_upc_active_cycles;

  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  hls_exec_monitor #(.SEQ_W(6), .UPC_W(1), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .finish(finish),
    .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done), .mod_continue(mod_continue),
    .seq_cur_state(seq_cur_state), .seq_pre_state(seq_pre_state), .seq_post_state(seq_post_state),
    .seq_iter_start_state(seq_iter_start_state), .seq_iter_end_state(seq_iter_end_state),
    .seq_post_valid(seq_post_valid), .seq_iter_end_valid(seq_iter_end_valid),
    .seq_one_state_loop(seq_one_state_loop), .seq_one_state_block(seq_one_state_block),
    .upc_cur_state(upc_cur_state), .upc_iter_start_state(upc_iter_start_state),
    .upc_iter_end_state(upc_iter_end_state), .upc_quit_state(upc_quit_state),
    .upc_iter_start_block(upc_iter_start_block), .upc_iter_end_block(upc_iter_end_block),
    .upc_quit_block(upc_quit_block), .upc_iter_start_enable(upc_iter_start_enable),
    .upc_iter_end_enable(upc_iter_end_enable), .upc_quit_enable(upc_quit_enable),
    .upc_loop_start(upc_loop_start), .upc_loop_ready(upc_loop_ready), .upc_loop_done(upc_loop_done),
    .upc_loop_continue(upc_loop_continue), .upc_quit_at_end(upc_quit_at_end),
    .frozen(frozen), .mod_busy(mod_busy), .mod_start_cnt(mod_start_cnt), .mod_done_cnt(mod_done_cnt),
    .mod_busy_cycles(mod_busy_cycles), .seq_active(seq_active), .seq_entry_cnt(seq_entry_cnt),
    .seq_iter_cnt(seq_iter_cnt), .seq_active_cycles(seq_active_cycles), .upc_active(upc_active),
    .upc_iter_start_cnt(upc_iter_start_cnt), .upc_iter_end_cnt(upc_iter_end_cnt),
    .upc_inflight(upc_inflight), .upc_active_cycles(upc_active_cycles)
  );

  hls_exec_monitor #(.SEQ_W(6), .UPC_W(1), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .finish(finish),
    .mod_start(mod_start), .mod_ready(mod_ready), .mod_done(mod_done), .mod_continue(mod_continue),
    .seq_cur_state(seq_cur_state), .seq_pre_state(seq_pre_state), .seq_post_state(seq_post_state),
    .seq_iter_start_state(seq_iter_start_state), .seq_iter_end_state(seq_iter_end_state),
    .seq_post_valid(seq_post_valid), .seq_iter_end_valid(seq_iter_end_valid),
    .seq_one_state_loop(seq_one_state_loop), .seq_one_state_block(seq_one_state_block),
    .upc_cur_state(upc_cur_state), .upc_iter_start_state(upc_iter_start_state),
    .upc_iter_end_state(upc_iter_end_state), .upc_quit_state(upc_quit_state),
    .upc_iter_start_block(upc_iter_start_block), .upc_iter_end_block(upc_iter_end_block),
    .upc_quit_block(upc_quit_block), .upc_iter_start_enable(upc_iter_start_enable),
    .upc_iter_end_enable(upc_iter_end_enable), .upc_quit_enable(upc_quit_enable),
    .upc_loop_start(upc_loop_start), .upc_loop_ready(upc_loop_ready), .upc_loop_done(upc_loop_done),
    .upc_loop_continue(upc_loop_continue), .upc_quit_at_end(upc_quit_at_end),
    .frozen(s_frozen), .mod_busy(s_mod_busy), .mod_start_cnt(s_mod_start_cnt),
    .mod_done_cnt(s_mod_done_cnt), .mod_busy_cycles(s_mod_busy_cycles), .seq_active(s_seq_active),
    .seq_entry_cnt(s_seq_entry_cnt), .seq_iter_cnt(s_seq_iter_cnt),
    .seq_active_cycles(s_seq_active_cycles), .upc_active(s_upc_active),
    .upc_iter_start_cnt(s_upc_iter_start_cnt), .upc_iter_end_cnt(s_upc_iter_end_cnt),
    .upc_inflight(s_upc_inflight), .upc_active_cycles(s_upc_active_cycles)
  );

  // one rising edge; inputs change and outputs are sampled on the falling edge
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check_all_zero(input string tag);
    vectors++;
    if ({frozen, mod_busy, seq_active, upc_active} !== 4'b0 ||
        {mod_start_cnt, mod_done_cnt, mod_busy_cycles, seq_entry_cnt, seq_iter_cnt,
         seq_active_cycles, upc_iter_start_cnt, upc_iter_end_cnt, upc_inflight,
         upc_active_cycles} !== '0) begin
      miscompares++;
      $display("FAIL %s main outputs: got flags=%b start=%0d done=%0d busy=%0d entry=%0d iter=%0d act=%0d us=%0d ue=%0d inf=%0d ua=%0d, required all 0",
               tag, {frozen, mod_busy, seq_active, upc_active}, mod_start_cnt, mod_done_cnt,
               mod_busy_cycles, seq_entry_cnt, seq_iter_cnt, seq_active_cycles,
               upc_iter_start_cnt, upc_iter_end_cnt, upc_inflight, upc_active_cycles);
    end
    vectors++;
    if ({s_frozen, s_mod_busy, s_seq_active, s_upc_active, s_mod_start_cnt, s_mod_done_cnt,
         s_mod_busy_cycles, s_seq_entry_cnt, s_seq_iter_cnt, s_seq_active_cycles,
         s_upc_iter_start_cnt, s_upc_iter_end_cnt, s_upc_inflight, s_upc_active_cycles} !== '0) begin
      miscompares++;
      $display("FAIL %s sat-instance outputs: got start=%0d busy=%0d flags=%b, required all 0",
               tag, s_mod_start_cnt, s_mod_busy_cycles,
               {s_frozen, s_mod_busy, s_seq_active, s_upc_active});
    end
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    #10;
    check_all_zero("reset");
    tick();
    reset = 1'b1;
  endtask

  task automatic test_handshake();
    mod_start = 1'b1; mod_ready = 1'b1;
    tick();
    mod_start = 1'b0; mod_ready = 1'b0;
    vectors++;
    if (mod_busy !== 1'b1 || mod_start_cnt !== 32'd1) begin
      miscompares++;
      $display("FAIL hs_enter: busy=%b start_cnt=%0d, required 1/1", mod_busy, mod_start_cnt);
    end
    repeat (9) tick();
    mod_done = 1'b1; mod_continue = 1'b1;
    tick();
    mod_done = 1'b0; mod_continue = 1'b0;
    vectors++;
    if ({mod_start_cnt, mod_done_cnt, mod_busy_cycles} !== {32'd1, 32'd1, 32'd10} || mod_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL hs_done: start=%0d done=%0d busy_cycles=%0d busy=%b, required 1/1/10/0",
               mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_busy);
    end
  endtask

  task automatic test_back_to_back();
    mod_start = 1'b1;
    tick();
    for (int k = 0; k < 3; k++) begin
      repeat (2) tick();
      mod_done = 1'b1; mod_continue = 1'b1;
      tick();
      mod_done = 1'b0; mod_continue = 1'b0;
      vectors++;
      if (mod_busy !== 1'b1 || mod_done_cnt !== 32'(2 + k)) begin
        miscompares++;
        $display("FAIL b2b_hold[%0d]: busy=%b done=%0d, required 1/%0d", k, mod_busy, mod_done_cnt, 2 + k);
      end
    end
    mod_start = 1'b0; mod_done = 1'b1; mod_continue = 1'b1;
    tick();
    mod_done = 1'b0; mod_continue = 1'b0;
    vectors++;
    if ({mod_start_cnt, mod_done_cnt, mod_busy_cycles} !== {32'd1, 32'd5, 32'd20} || mod_busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_end: start=%0d done=%0d busy_cycles=%0d busy=%b, required 1/5/20/0",
               mod_start_cnt, mod_done_cnt, mod_busy_cycles, mod_busy);
    end
  endtask

  task automatic test_seq_loop();
    logic [5:0] states [18] = '{6'd2, 6'd3, 6'd4, 6'd5, 6'd2, 6'd3, 6'd4, 6'd5, 6'd2,
                                6'd3, 6'd4, 6'd5, 6'd2, 6'd3, 6'd4, 6'd5, 6'd2, 6'd6};
    seq_post_valid = 1'b1; seq_iter_end_valid = 1'b1;
    for (int i = 0; i < 18; i++) begin
      seq_cur_state = states[i];
      tick();
      if (i == 0) begin
        vectors++;
        if (seq_active !== 1'b1 || seq_entry_cnt !== 32'd1 || seq_active_cycles !== 32'd0) begin
          miscompares++;
          $display("FAIL seq_entry: active=%b entry=%0d cycles=%0d, required 1/1/0",
                   seq_active, seq_entry_cnt, seq_active_cycles);
        end
      end
    end
    seq_cur_state = 6'd1;
    vectors++;
    if ({seq_entry_cnt, seq_iter_cnt, seq_active_cycles} !== {32'd1, 32'd4, 32'd17} || seq_active !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_loop: entry=%0d iter=%0d cycles=%0d active=%b, required 1/4/17/0",
               seq_entry_cnt, seq_iter_cnt, seq_active_cycles, seq_active);
    end
  endtask

  task automatic test_one_state_loop();
    logic [5:0] states [5] = '{6'd2, 6'd2, 6'd2, 6'd2, 6'd6};
    logic       blk    [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    seq_one_state_loop = 1'b1;
    for (int i = 0; i < 5; i++) begin
      seq_cur_state = states[i]; seq_one_state_block = blk[i];
      tick();
    end
    seq_cur_state = 6'd1; seq_one_state_loop = 1'b0; seq_one_state_block = 1'b0;
    vectors++;
    if ({seq_entry_cnt, seq_iter_cnt, seq_active_cycles} !== {32'd2, 32'd7, 32'd21} || seq_active !== 1'b0) begin
      miscompares++;
      $display("FAIL seq_one_state: entry=%0d iter=%0d cycles=%0d active=%b, required 2/7/21/0",
               seq_entry_cnt, seq_iter_cnt, seq_active_cycles, seq_active);
    end
  endtask

  task automatic test_pipeline();
    logic sen [13] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
    logic sbl [13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    logic een [13] = '{0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    int   inf [13] = '{1, 2, 3, 3, 3, 3, 3, 4, 4, 3, 2, 1, 0};
    upc_loop_start = 1'b1;
    tick();
    upc_loop_start = 1'b0;
    vectors++;
    if (upc_active !== 1'b1) begin
      miscompares++;
      $display("FAIL upc_enter: active=%b, required 1", upc_active);
    end
    for (int c = 0; c < 13; c++) begin
      upc_iter_start_enable = sen[c]; upc_iter_start_block = sbl[c]; upc_iter_end_enable = een[c];
      tick();
      vectors++;
      if (upc_inflight !== 32'(inf[c])) begin
        miscompares++;
        $display("FAIL upc_inflight[%0d]: got %0d, required %0d", c, upc_inflight, inf[c]);
      end
    end
    upc_iter_start_enable = 1'b0; upc_iter_start_block = 1'b0; upc_iter_end_enable = 1'b0;
    upc_loop_done = 1'b1; upc_loop_continue = 1'b1;
    tick();
    upc_loop_done = 1'b0; upc_loop_continue = 1'b0;
    vectors++;
    if ({upc_iter_start_cnt, upc_iter_end_cnt, upc_active_cycles} !== {32'd8, 32'd8, 32'd14} || upc_active !== 1'b0) begin
      miscompares++;
      $display("FAIL upc_done: starts=%0d ends=%0d cycles=%0d active=%b, required 8/8/14/0",
               upc_iter_start_cnt, upc_iter_end_cnt, upc_active_cycles, upc_active);
    end
  endtask

  task automatic test_quit_and_clamp();
    upc_loop_start = 1'b1; upc_loop_ready = 1'b1;
    tick();
    upc_loop_start = 1'b0; upc_loop_ready = 1'b0;
    upc_cur_state = 1'b1; upc_quit_enable = 1'b1; upc_quit_at_end = 1'b1;
    tick();
    vectors++;
    if (upc_active !== 1'b1) begin
      miscompares++;
      $display("FAIL quit_at_end_hold: active=%b, required 1", upc_active);
    end
    upc_quit_at_end = 1'b0;
    tick();
    vectors++;
    if (upc_active !== 1'b0 || upc_active_cycles !== 32'd16) begin
      miscompares++;
      $display("FAIL quit_exit: active=%b cycles=%0d, required 0/16", upc_active, upc_active_cycles);
    end
    upc_cur_state = 1'b0; upc_quit_enable = 1'b0; upc_iter_end_enable = 1'b1;
    tick();
    upc_iter_end_enable = 1'b0;
    vectors++;
    if (upc_inflight !== 32'd0 || upc_iter_end_cnt !== 32'd9) begin
      miscompares++;
      $display("FAIL inflight_clamp0: inflight=%0d ends=%0d, required 0/9", upc_inflight, upc_iter_end_cnt);
    end
  endtask

  task automatic test_freeze();
    mod_start = 1'b1; mod_ready = 1'b1;
    tick();
    mod_start = 1'b0; mod_ready = 1'b0;
    repeat (3) tick();
    finish = 1'b1; mod_done = 1'b1; mod_continue = 1'b1; seq_cur_state = 6'd2;
    tick();
    finish = 1'b0;
    for (int c = 0; c < 20; c++) begin
      mod_start = 1'b1; mod_ready = 1'b1; upc_iter_start_enable = 1'b1; upc_loop_start = c[0];
      seq_cur_state = c[0] ? 6'd5 : 6'd2;
      tick();
      vectors++;
      if (frozen !== 1'b1 || mod_busy !== 1'b1 ||
          {mod_start_cnt, mod_done_cnt, mod_busy_cycles} !== {32'd2, 32'd5, 32'd23} ||
          {seq_entry_cnt, seq_iter_cnt, seq_active_cycles} !== {32'd2, 32'd7, 32'd21} ||
          {upc_iter_start_cnt, upc_iter_end_cnt, upc_active_cycles} !== {32'd8, 32'd9, 32'd16} ||
          {seq_active, upc_active} !== 2'b00) begin
        miscompares++;
        $display("FAIL freeze_hold[%0d]: frozen=%b busy=%b start=%0d done=%0d bc=%0d entry=%0d iter=%0d sa=%0d us=%0d ue=%0d ua=%0d, required 1/1/2/5/23/2/7/21/8/9/16",
                 c, frozen, mod_busy, mod_start_cnt, mod_done_cnt, mod_busy_cycles, seq_entry_cnt,
                 seq_iter_cnt, seq_active_cycles, upc_iter_start_cnt, upc_iter_end_cnt, upc_active_cycles);
      end
    end
  endtask

  task automatic test_reset_clear();
    #2 reset = 1'b0;
    #2;
    check_all_zero("midrun_reset");
    mod_start = 1'b0; mod_ready = 1'b0; mod_done = 1'b0; mod_continue = 1'b0;
    upc_iter_start_enable = 1'b0; upc_loop_start = 1'b0; seq_cur_state = 6'd1;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_saturation();
    mod_start = 1'b1; mod_ready = 1'b1;
    repeat (20) tick();
    mod_start = 1'b0; mod_ready = 1'b0;
    vectors++;
    if (s_mod_start_cnt !== 4'd15 || s_mod_busy_cycles !== 4'd15) begin
      miscompares++;
      $display("FAIL sat4: start=%0d busy_cycles=%0d, required 15/15", s_mod_start_cnt, s_mod_busy_cycles);
    end
    vectors++;
    if (mod_start_cnt !== 32'd20 || mod_busy_cycles !== 32'd19 || frozen !== 1'b0) begin
      miscompares++;
      $display("FAIL sat32: start=%0d busy_cycles=%0d frozen=%b, required 20/19/0",
               mod_start_cnt, mod_busy_cycles, frozen);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_back_to_back();
    test_seq_loop();
    test_one_state_loop();
    test_pipeline();
    test_quit_and_clamp();
    test_freeze();
    test_reset_clear();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hls_exec_monitor.md
# hls_exec_monitor

Synthesizable execution-profiling monitor for an HLS-generated accelerator. It observes one block-level ap_* handshake, one sequential FSM loop and one pipelined (UPC) loop. It keeps saturating event and cycle counters for each. It sits beside the accelerator core, wired to its FSM state registers and control strobes, and freezes all statistics when `finish` is raised.

## Interface
Parameters:
- SEQ_W, 6: width of sequential-loop state code (one-hot FSM).
- UPC_W, 1: width of pipelined-loop state code.
- CNT_W, 32: width of every counter output.

Ports:
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- finish  in  1  end-of-run; sticky freeze of all state.
- mod_start, mod_ready, mod_done, mod_continue  in  1 each  monitored block handshake.
- seq_cur_state, seq_pre_state, seq_post_state, seq_iter_start_state, seq_iter_end_state  in  SEQ_W each  current state and reference state codes.
- seq_post_valid, seq_iter_end_valid, seq_one_state_loop, seq_one_state_block  in  1 each  qualifiers.
- upc_cur_state, upc_iter_start_state, upc_iter_end_state, upc_quit_state  in  UPC_W each.
- upc_iter_start_block, upc_iter_end_block, upc_quit_block  in  1 each  stage stall flags; 1 = stalled.
- upc_iter_start_enable, upc_iter_end_enable, upc_quit_enable  in  1 each  pipeline stage-enable flags.
- upc_loop_start, upc_loop_ready, upc_loop_done, upc_loop_continue, upc_quit_at_end  in  1 each.
- frozen  out  1  set once `finish` has been sampled.
- mod_busy  out  1; mod_start_cnt, mod_done_cnt, mod_busy_cycles  out  CNT_W each.
- seq_active  out  1; seq_entry_cnt, seq_iter_cnt, seq_active_cycles  out  CNT_W each.
- upc_active  out  1; upc_iter_start_cnt, upc_iter_end_cnt, upc_inflight, upc_active_cycles  out  CNT_W each.

## Operation
- All outputs are registered. All outputs reset to 0 while reset is low.
- Counters saturate at all-ones and never wrap.
- Freeze:
  - On a rising edge with finish=1, frozen←1.
  - From that edge on, every FSM and counter holds, including that edge's updates.
  - Only reset clears the freeze.
- Module monitor, FSM IDLE/BUSY (mod_busy = BUSY):
  - IDLE→BUSY when mod_start=1.
  - BUSY→IDLE when mod_done&mod_continue and mod_start=0. With mod_start=1 it stays BUSY (back-to-back transaction).
  - mod_start_cnt increments on mod_start&mod_ready.
  - mod_done_cnt increments on mod_done&mod_continue.
  - mod_busy_cycles increments every cycle the registered state is BUSY.
- Sequential loop:
  - prev_state is a register of seq_cur_state; reset value 0.
  - "Enter X" means cur==X && prev!=X.
  - FSM OUT/IN (seq_active = IN).
  - OUT→IN on enter iter_start_state; seq_entry_cnt++.
  - IN→OUT on enter post_state while seq_post_valid=1.
  - While IN or on the entry edge: seq_iter_cnt++ on enter iter_end_state while seq_iter_end_valid=1.
  - If seq_one_state_loop=1, iterations are counted differently: +1 every cycle with cur==iter_start_state and seq_one_state_block=0.
  - seq_active_cycles increments every cycle in IN.
  - Equality compare is full-width. pre_state is used only for documentation and debug and has no effect.
- Pipelined loop:
  - start_evt = cur==iter_start_state & !iter_start_block & iter_start_enable.
  - end_evt = cur==iter_end_state & !iter_end_block & iter_end_enable.
  - quit_evt = cur==quit_state & !quit_block & quit_enable.
  - upc_iter_start_cnt += start_evt; upc_iter_end_cnt += end_evt.
  - upc_inflight += start_evt − end_evt, clamped at 0 and at all-ones. Simultaneous start and end leaves it unchanged.
  - FSM IDLE/ACTIVE (upc_active = ACTIVE).
  - IDLE→ACTIVE on upc_loop_start&upc_loop_ready, or on upc_loop_start rising from 0.
  - ACTIVE→IDLE on upc_loop_done&upc_loop_continue. It also exits on quit_evt when upc_quit_at_end=0.
  - upc_active_cycles increments every cycle in ACTIVE.

## Timing
- An event sampled at edge N is visible on outputs after edge N; there is no additional latency.
- The cycle counters count the cycle after the state transition. The entry cycle itself is not counted.
- Reset asserted mid-run clears everything asynchronously, including frozen. The first edge after release is a normal edge.
- Priority when events coincide in the same cycle:
  - freeze beats all other updates;
  - exit beats entry;
  - counter increments beat FSM transitions (both are applied).

## Test plan
- Handshake: mod_start=1 for 1 cycle with mod_ready=1, mod_done pulse 10 cycles later, continue=1 → start_cnt=1, done_cnt=1, busy_cycles=10, mod_busy=0.
- Back-to-back: mod_start held high through 3 done pulses → mod_busy stays 1; done_cnt=3.
- Sequential loop: drive states 1→2→3→4→5→2 ×4 iterations, then 2→6 with post_valid=1 → entry_cnt=1, iter_cnt=4, seq_active=0.
- Pipelined loop: loop_start, 8 start_evts, end_evts delayed 4 cycles, one cycle of start_block=1 mid-run → iter_start_cnt=8, iter_end_cnt=8, inflight peaks at 4 and ends 0, active clears on done.
- Freeze: raise finish mid-loop → all counters constant for 20 further cycles; frozen=1. Pulse reset low → all outputs 0.
- Saturation: CNT_W=4, 20 start events → mod_start_cnt=15.
